// File: rtl/sort_loader_pkg.sv
// ============================================================================
// Module : sort_loader_pkg
// Brief  : Shared sorter constants and loader state encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sort_loader_pkg;

  localparam int SORT_DEPTH = 256;
  localparam int SORT_AW    = 8;
  localparam int SORT_DW    = 16;

  typedef enum logic [2:0] {
    L_IDLE = 3'd0,
    L_LOAD = 3'd1,
    L_KICK = 3'd2,
    L_WAIT = 3'd3,
    L_DONE = 3'd4
  } load_state_t;

endpackage

`default_nettype wire

// File: rtl/load_addr_counter.sv
// ============================================================================
// Module : load_addr_counter
// Brief  : AW-bit write address counter with clear, enable and terminal count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module load_addr_counter #(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] cnt,
  output logic          tc
);

  localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

  logic [AW-1:0] r_cnt;

  assign tc  = (r_cnt == c_last);
  assign cnt = r_cnt;

  // Explicit wrap so a DEPTH smaller than 2**AW still restarts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (clr)
      r_cnt <= '0;
    else if (en)
      r_cnt <= tc ? '0 : r_cnt + 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/sort_loader.sv
// ============================================================================
// Module : sort_loader
// Brief  : Streams DEPTH words into sorter memory, kicks the sorter, reports done.
//          Optional batch checksum enabled by defining CHECKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sort_loader
  import sort_loader_pkg::*;
#(
  parameter int DEPTH = SORT_DEPTH,
  parameter int AW    = SORT_AW,
  parameter int DW    = SORT_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_go,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_rdy,
  output logic          sort_start,
  input  logic          sort_done,
  output logic          busy,
  output logic          sorted,
  output logic [DW-1:0] checksum
);

  load_state_t   r_state;
  load_state_t   w_state_n;
  logic          w_go;
  logic          w_accept;
  logic          w_in_load;
  logic [AW-1:0] w_cnt;
  logic          w_tc;
  logic          r_sort_start;
  logic          r_busy;
  logic          r_sorted;

  load_addr_counter #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_addr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_go),
    .en  (w_accept),
    .cnt (w_cnt),
    .tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= L_IDLE;
    else
      r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    w_go      = 1'b0;
    w_in_load = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      L_IDLE: begin
        if (load_go) begin
          w_go      = 1'b1;
          w_state_n = L_LOAD;
        end
      end
      L_LOAD: begin
        w_in_load = 1'b1;
        w_accept  = in_valid & mem_rdy;
        if (w_accept && w_tc)
          w_state_n = L_KICK;
      end
      L_KICK:  w_state_n = L_WAIT;
      L_WAIT:  if (sort_done) w_state_n = L_DONE;
      L_DONE:  w_state_n = L_IDLE;
      default: w_state_n = L_IDLE;
    endcase
  end

  assign in_ready  = w_in_load & mem_rdy;
  assign mem_write = w_accept;
  assign mem_addr  = w_in_load ? w_cnt   : '0;
  assign mem_wdata = w_in_load ? in_data : '0;

  // Status outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sort_start <= 1'b0;
      r_busy       <= 1'b0;
      r_sorted     <= 1'b0;
    end else begin
      r_sort_start <= (w_state_n == L_KICK);
      r_busy       <= (w_state_n != L_IDLE);
      r_sorted     <= (w_state_n == L_DONE);
    end
  end

  assign sort_start = r_sort_start;
  assign busy       = r_busy;
  assign sorted     = r_sorted;

`ifdef CHECKSUM_EN
  logic [DW-1:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_checksum <= '0;
    else if (w_go)
      r_checksum <= '0;
    else if (w_accept)
      r_checksum <= r_checksum + in_data;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sort_loader.sv
// ============================================================================
// Module : tb_sort_loader
// Brief  : Directed self-checking bench for sort_loader.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sort_loader;
  import sort_loader_pkg::*;

  localparam int DEPTH = SORT_DEPTH;
  localparam int AW    = SORT_AW;
  localparam int DW    = SORT_DW;

`ifdef CHECKSUM_EN
  localparam logic [31:0] c_sum_desc = 32'h7F80;
  localparam logic [31:0] c_sum_0101 = 32'h0100;
`else
  localparam logic [31:0] c_sum_desc = 32'h0;
  localparam logic [31:0] c_sum_0101 = 32'h0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          load_go;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rdy;
  logic          sort_start;
  logic          sort_done;
  logic          busy;
  logic          sorted;
  logic [DW-1:0] checksum;

  always #5 clk = ~clk;

  sort_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_go    (load_go),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdy    (mem_rdy),
    .sort_start (sort_start),
    .sort_done  (sort_done),
    .busy       (busy),
    .sorted     (sorted),
    .checksum   (checksum)
  );

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor, sampled on the falling edge.
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  int ss_cnt  = 0;
  int bad_wr  = 0;

  always @(negedge clk) begin
    if (mem_write) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      if (!mem_rdy) bad_wr++;
    end
    if (sort_start) ss_cnt++;
  end

  function automatic logic [DW-1:0] word_of(input int mode, input int i);
    case (mode)
      0:       return DW'(255 - i);
      1:       return DW'(32'h1000 + i);
      default: return 16'h0101;
    endcase
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 after the n-th accepted beat.
  task automatic stream(input int n, input int mode, input bit alt);
    int  acc_n = 0;
    int  cyc   = 0;
    bit  acc;
    while (acc_n < n && cyc < n * 4 + 20) begin
      in_valid = 1'b1;
      in_data  = word_of(mode, acc_n);
      mem_rdy  = alt ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) acc_n++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    mem_rdy  = 1'b1;
    if (acc_n < n) check("stream_timeout", 32'(acc_n), 32'(n));
  endtask

  task automatic check_writes(input string tag, input int mode, input int n);
    int errs = 0;
    check({tag, "_count"}, 32'(wr_addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== word_of(mode, i)) errs++;
    end
    check({tag, "_content"}, 32'(errs), 32'd0);
  endtask

  task automatic pulse_go();
    load_go = 1'b1;
    @(posedge clk); #1;
    load_go = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  int ss0;

  initial begin
    rst = 1'b1; load_go = 1'b0; in_valid = 1'b0; in_data = '0;
    mem_rdy = 1'b1; sort_done = 1'b0;
    tick(3);
    check("rst_busy",     32'(busy),       32'd0);
    check("rst_sorted",   32'(sorted),     32'd0);
    check("rst_start",    32'(sort_start), 32'd0);
    check("rst_ready",    32'(in_ready),   32'd0);
    check("rst_write",    32'(mem_write),  32'd0);
    check("rst_checksum", 32'(checksum),   32'd0);
    rst = 1'b0;
    tick(1);

    // Full descending batch, sort_done during KICK is ignored.
    clear_mon(); ss0 = ss_cnt;
    in_valid = 1'b1;
    check("idle_ready", 32'(in_ready), 32'd0);
    check("idle_write", 32'(mem_write), 32'd0);
    in_valid = 1'b0;
    pulse_go();
    check("t1_busy", 32'(busy), 32'd1);
    stream(256, 0, 1'b0);
    check("t1_kick_start", 32'(sort_start), 32'd1);
    check("t1_kick_busy",  32'(busy),       32'd1);
    check("t1_kick_ready", 32'(in_ready),   32'd0);
    check("t1_checksum",   32'(checksum),   c_sum_desc);
    sort_done = 1'b1;
    tick(1);
    sort_done = 1'b0;
    check("t1_start_once", 32'(sort_start), 32'd0);
    check("t3_kick_done_ignored", 32'(sorted), 32'd0);
    check_writes("t1_writes", 0, 256);
    check("t1_ss_cnt", 32'(ss_cnt - ss0), 32'd1);

    // load_go and in_valid in WAIT are ignored.
    load_go = 1'b1; in_valid = 1'b1;
    check("t4_wait_write", 32'(mem_write), 32'd0);
    tick(1);
    load_go = 1'b0;
    check("t4_busy",  32'(busy),     32'd1);
    check("t4_ready", 32'(in_ready), 32'd0);
    tick(8);
    in_valid = 1'b0;
    check("t4_no_writes", 32'(wr_addr_q.size()), 32'd256);
    check("t4_sorted_low", 32'(sorted), 32'd0);
    sort_done = 1'b1;
    tick(1);
    sort_done = 1'b0;
    check("t3_sorted", 32'(sorted), 32'd1);
    check("t3_done_busy", 32'(busy), 32'd1);
    tick(1);
    check("t3_sorted_pulse", 32'(sorted), 32'd0);
    check("t3_idle_busy", 32'(busy), 32'd0);

    // Backpressure: mem_rdy low every other cycle.
    clear_mon(); ss0 = ss_cnt; bad_wr = 0;
    pulse_go();
    stream(256, 1, 1'b1);
    check("t2_start", 32'(sort_start), 32'd1);
    check_writes("t2_writes", 1, 256);
    check("t2_write_wo_rdy", 32'(bad_wr), 32'd0);
    tick(1);
    sort_done = 1'b1;
    tick(1);
    sort_done = 1'b0;
    check("t2_sorted", 32'(sorted), 32'd1);
    check("t2_ss_cnt", 32'(ss_cnt - ss0), 32'd1);
    tick(1);

    // Reset mid-load abandons the batch.
    clear_mon(); ss0 = ss_cnt;
    pulse_go();
    stream(100, 1, 1'b0);
    check("t5_partial", 32'(wr_addr_q.size()), 32'd100);
    in_valid = 1'b1; in_data = 16'h1234;
    check("t5_pre_rst_addr", 32'(mem_addr), 32'd100);
    rst = 1'b1;
    #1;
    check("t5_rst_busy",  32'(busy),      32'd0);
    check("t5_rst_ready", 32'(in_ready),  32'd0);
    check("t5_rst_write", 32'(mem_write), 32'd0);
    check("t5_rst_addr",  32'(mem_addr),  32'd0);
    check("t5_rst_wdata", 32'(mem_wdata), 32'd0);
    check("t5_rst_start", 32'(sort_start), 32'd0);
    in_valid = 1'b0; in_data = '0;
    tick(1);
    rst = 1'b0;
    tick(3);
    check("t5_no_start", 32'(ss_cnt - ss0), 32'd0);
    clear_mon();
    pulse_go();
    stream(1, 0, 1'b0);
    check("t5_restart_cnt", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() > 0) check("t5_restart_addr", 32'(wr_addr_q[0]), 32'd0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick(1);

    // Checksum wraps for 256 x 0x0101; cleared on next load_go.
    clear_mon();
    pulse_go();
    stream(256, 2, 1'b0);
    check("t6_checksum_kick", 32'(checksum), c_sum_0101);
    tick(3);
    check("t6_checksum_stable", 32'(checksum), c_sum_0101);
    sort_done = 1'b1;
    tick(1);
    sort_done = 1'b0;
    tick(1);
    check("t6_idle", 32'(busy), 32'd0);
    check("t6_checksum_idle", 32'(checksum), c_sum_0101);
    pulse_go();
    check("t6_checksum_clr", 32'(checksum), 32'd0);
    check("t6_addr_zero", 32'(mem_addr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
